// File: rtl/requant_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : requant_pkg                                                  |
// | Description : Shared types and constants for the requantisation stage.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package requant_pkg;

  localparam int LANES_DEF     = 4;
  localparam int ACC_W_DEF     = 24;
  localparam int BIAS_W_DEF    = 8;
  localparam int MUL_W_DEF     = 15;
  localparam int OUT_W_DEF     = 8;
  localparam int SHIFT_W       = 6;
  localparam int MAX_SHIFT_DEF = 38;
  localparam int DEPTH_DEF     = 64;
  localparam int LATENCY       = 5;

  // One per-channel parameter entry; signed fields are reinterpreted at use.
  typedef struct packed {
    logic [BIAS_W_DEF-1:0] bias;
    logic [MUL_W_DEF-1:0]  mul;
    logic [SHIFT_W-1:0]    shift;
    logic [OUT_W_DEF-1:0]  out_offset;
    logic [OUT_W_DEF-1:0]  act_min;
    logic [OUT_W_DEF-1:0]  act_max;
  } rq_param_t;

  // 16-bit add that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rq_param_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rq_param_ram                                                 |
// | Description : Simple dual-port parameter table, registered read-first      |
// |               output with read enable; contents are not reset.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rq_param_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 53
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port: accepted every cycle, independent of pipeline stalls.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: non-blocking sample returns the old word on a same-address write.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/requant_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : requant_stream                                               |
// | Description : Five-stage multi-lane requantisation: bias, multiply,        |
// |               round-half-up shift, offset and clamp, with valid/ready      |
// |               backpressure and a saturating clamp counter.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module requant_stream
  import requant_pkg::*;
#(
  parameter int LANES     = LANES_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int BIAS_W    = BIAS_W_DEF,
  parameter int MUL_W     = MUL_W_DEF,
  parameter int OUT_W     = OUT_W_DEF,
  parameter int MAX_SHIFT = MAX_SHIFT_DEF,
  parameter int DEPTH     = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
  input  logic [$bits(rq_param_t)-1:0] cfg_wdata,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [$clog2(DEPTH)-1:0]   in_ch,
  input  logic [LANES*ACC_W-1:0]     in_acc,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*OUT_W-1:0]     out_data,
  output logic [LANES-1:0]           out_sat,
  output logic                       out_last,
  output logic [15:0]                sat_cnt
);

  localparam int T_W = ACC_W + 1;           // bias-added value
  localparam int P_W = ACC_W + MUL_W + 2;   // product
  localparam int R_W = P_W + 1;             // product plus rounding constant
  localparam int Y_W = R_W + 1;             // shifted value plus offset

  logic stall;
  logic adv;

  // Per-stage valid / last bits (bubbles travel as valid=0).
  logic v1_q, v2_q, v3_q, v4_q;
  logic last1_q, last2_q, last3_q, last4_q;

  // Stage payloads.
  logic [LANES*ACC_W-1:0] acc1_q;
  rq_param_t              p1;
  logic [$bits(rq_param_t)-1:0] w_p1_raw;
  logic [MUL_W-1:0]       mul2_q;
  logic [SHIFT_W-1:0]     shift2_q, shift3_q;
  logic [OUT_W-1:0]       off2_q, off3_q, off4_q;
  logic [OUT_W-1:0]       min2_q, min3_q, min4_q;
  logic [OUT_W-1:0]       max2_q, max3_q, max4_q;

  // Output register and its next value.
  logic                   out_valid_q;
  logic [LANES*OUT_W-1:0] out_data_q, out_data_d;
  logic [LANES-1:0]       out_sat_q, out_sat_d;
  logic                   out_last_q;
  logic [15:0]            sat_cnt_q, sat_cnt_d;

  assign stall    = out_valid_q && !out_ready;
  assign adv      = !stall;
  assign in_ready = adv;

  // S1 parameter lookup; the read enable freezes the entry while stalled.
  rq_param_ram #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(rq_param_t))
  ) u_param_ram (
    .clk     (clk),
    .we_i    (cfg_we),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_wdata),
    .re_i    (adv),
    .raddr_i (in_ch),
    .rdata_o (w_p1_raw)
  );

  assign p1 = rq_param_t'(w_p1_raw);

  // Valid and last bits advance together; reset drops every in-flight beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      v4_q    <= 1'b0;
      last1_q <= 1'b0;
      last2_q <= 1'b0;
      last3_q <= 1'b0;
      last4_q <= 1'b0;
    end else if (adv) begin
      v1_q    <= in_valid;
      v2_q    <= v1_q;
      v3_q    <= v2_q;
      v4_q    <= v3_q;
      last1_q <= in_valid && in_last;
      last2_q <= last1_q;
      last3_q <= last2_q;
      last4_q <= last3_q;
    end
  end

  // Shared-channel payload pipeline; only fields still needed are carried on.
  always_ff @(posedge clk) begin
    if (adv) begin
      acc1_q   <= in_acc;
      mul2_q   <= p1.mul;
      shift2_q <= p1.shift;
      off2_q   <= p1.out_offset;
      min2_q   <= p1.act_min;
      max2_q   <= p1.act_max;
      shift3_q <= shift2_q;
      off3_q   <= off2_q;
      min3_q   <= min2_q;
      max3_q   <= max2_q;
      off4_q   <= off3_q;
      min4_q   <= min3_q;
      max4_q   <= max3_q;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [ACC_W-1:0]  w_acc;
    logic signed [BIAS_W-1:0] w_bias;
    logic signed [T_W-1:0]    w_t;
    logic signed [T_W-1:0]    t2_q;
    logic signed [MUL_W:0]    w_mul;
    logic signed [P_W-1:0]    w_prod;
    logic signed [P_W-1:0]    m3_q;
    logic signed [R_W-1:0]    w_one;
    logic signed [R_W-1:0]    w_rnd;
    logic [SHIFT_W:0]         w_sh;
    logic signed [R_W-1:0]    w_shr;
    logic signed [R_W-1:0]    r4_q;
    logic signed [Y_W-1:0]    w_r;
    logic signed [Y_W-1:0]    w_min;
    logic signed [Y_W-1:0]    w_max;
    logic signed [Y_W-1:0]    w_lo;
    logic signed [Y_W-1:0]    w_y;

    // S2: bias add, one guard bit so it cannot overflow.
    assign w_acc  = $signed(acc1_q[g*ACC_W +: ACC_W]);
    assign w_bias = $signed(p1.bias);
    assign w_t    = T_W'(w_acc) + T_W'(w_bias);

    // S3: product as its own net so the multiplier maps to a DSP.
    assign w_mul  = $signed({1'b0, mul2_q});
    assign w_prod = P_W'(t2_q) * P_W'(w_mul);

    // S4: add half an LSB of the result, then shift right by shift+1.
    assign w_one = R_W'(1);
    assign w_rnd = R_W'(m3_q) + (w_one <<< shift3_q);
    assign w_sh  = {1'b0, shift3_q} + 7'd1;
    assign w_shr = w_rnd >>> w_sh;

    // S5: offset then max-with-min, min-with-max so min>max yields act_max.
    assign w_r   = Y_W'(r4_q) + Y_W'($signed(off4_q));
    assign w_min = Y_W'($signed(min4_q));
    assign w_max = Y_W'($signed(max4_q));
    assign w_lo  = (w_r < w_min) ? w_min : w_r;
    assign w_y   = (w_lo > w_max) ? w_max : w_lo;

    assign out_data_d[g*OUT_W +: OUT_W] = w_y[OUT_W-1:0];
    assign out_sat_d[g]                 = (w_y != w_r);

    // Lane arithmetic registers, held while the stage is stalled.
    always_ff @(posedge clk) begin
      if (adv) begin
        t2_q <= w_t;
        m3_q <= w_prod;
        r4_q <= w_shr;
      end
    end
  end

  // Next counter value: add this handshake's clamped lanes, sticking at max.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (out_valid_q && out_ready) begin
      sat_cnt_d = sat_add16(sat_cnt_q, 16'($countones(out_sat_q)));
    end
  end

  // Output register and clamp counter; both cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
      out_last_q  <= 1'b0;
      sat_cnt_q   <= 16'd0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
      if (adv) begin
        out_valid_q <= v4_q;
        out_data_q  <= out_data_d;
        out_sat_q   <= out_sat_d;
        out_last_q  <= last4_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_last  = out_last_q;
  assign sat_cnt   = sat_cnt_q;

  // A beat entering S2 must carry a legal shift field.
  a_shift_legal : assert property (@(posedge clk) disable iff (!rst_n)
    v1_q |-> ({1'b0, p1.shift} <= 7'(MAX_SHIFT)));

endmodule
`default_nettype wire

// File: tb/tb_requant_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_requant_stream                                            |
// | Description : Self-checking bench for requant_stream: vector table,        |
// |               scoreboard queue, backpressure, collision and reset cases.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_requant_stream;
  import requant_pkg::*;

  localparam int LANES = 4;
  localparam int ACC_W = 24;
  localparam int OUT_W = 8;
  localparam int AW    = 6;
  localparam int PW    = $bits(rq_param_t);

  logic                   clk;
  logic                   rst_n;
  logic                   cfg_we;
  logic [AW-1:0]          cfg_addr;
  logic [PW-1:0]          cfg_wdata;
  logic                   in_valid;
  logic                   in_ready;
  logic [AW-1:0]          in_ch;
  logic [LANES*ACC_W-1:0] in_acc;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*OUT_W-1:0] out_data;
  logic [LANES-1:0]       out_sat;
  logic                   out_last;
  logic [15:0]            sat_cnt;

  requant_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_acc    (in_acc),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_last  (out_last),
    .sat_cnt   (sat_cnt)
  );

  typedef struct {
    rq_param_t  p;
    int         ch;
    int         acc[4];
    int         y[4];
    logic [3:0] sat;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  sat;
    logic        last;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  vec_t        vt[5];
  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [15:0] exp_cnt  = 16'd0;
  bit          bp_mode  = 0;
  int          bp_cnt   = 0;
  bit          prev_stall = 0;
  logic [31:0] sv_data;
  logic [3:0]  sv_sat;
  logic        sv_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic rq_param_t mk(input int b, input int m, input int s,
                                   input int o, input int mn, input int mx);
    rq_param_t p;
    p.bias       = 8'(b);
    p.mul        = 15'(m);
    p.shift      = 6'(s);
    p.out_offset = 8'(o);
    p.act_min    = 8'(mn);
    p.act_max    = 8'(mx);
    return p;
  endfunction

  function automatic logic [95:0] pack_acc(input int a[4]);
    logic [95:0] v;
    for (int i = 0; i < 4; i++) v[i*24 +: 24] = 24'(a[i]);
    return v;
  endfunction

  function automatic exp_t exp_from(input int y[4], input logic [3:0] s,
                                    input logic last, input bit lat);
    exp_t e;
    for (int i = 0; i < 4; i++) e.data[i*8 +: 8] = 8'(y[i]);
    e.sat = s; e.last = last; e.acc_cyc = 0; e.chk_lat = lat;
    return e;
  endfunction

  // Reference arithmetic in 64-bit integers, straight from the definition.
  function automatic exp_t model_beat(input rq_param_t p, input int a[4], input logic last);
    int         y[4];
    logic [3:0] s;
    longint     t, m, r, mn, mx, lo, yy;
    int         sh;
    for (int i = 0; i < 4; i++) begin
      sh = int'(p.shift);
      t  = longint'(a[i]) + longint'($signed(p.bias));
      m  = t * longint'(p.mul);
      r  = ((m + (longint'(1) <<< sh)) >>> (sh + 1)) + longint'($signed(p.out_offset));
      mn = longint'($signed(p.act_min));
      mx = longint'($signed(p.act_max));
      lo = (r < mn) ? mn : r;
      yy = (lo > mx) ? mx : lo;
      y[i] = int'(yy);
      s[i] = (yy != r);
    end
    return exp_from(y, s, last, 1'b0);
  endfunction

  task automatic cfg_write(input int addr, input rq_param_t p);
    cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_wdata = p;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_beat(input int ch, input logic [95:0] acc, input logic last, input exp_t e);
    bit done;
    done = 0;
    in_valid = 1'b1; in_ch = AW'(ch); in_acc = acc; in_last = last;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        e.acc_cyc = cyc + 1;
        q.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: got no in_ready, expected acceptance within 200 cycles");
    end
  endtask

  task automatic drain(input int limit);
    for (int k = 0; k < limit && q.size() != 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("drain_empty", q.size(), 0);
  endtask

  // Downstream ready: constant 1, or the 1-0-0-1 pattern under backpressure.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_mode) begin
        out_ready = ((bp_cnt % 4) == 0) || ((bp_cnt % 4) == 3);
        bp_cnt++;
      end else begin
        out_ready = 1'b1;
        bp_cnt = 0;
      end
    end
  end

  // Output monitor: scoreboard pop, handshake rule, stall stability, counter.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        check("in_ready_rule", in_ready, !(out_valid && !out_ready));
        check("sat_cnt", sat_cnt, exp_cnt);
        if (prev_stall) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, sv_data);
          check("hold_sat", out_sat, sv_sat);
          check("hold_last", out_last, sv_last);
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_output: got data %h, expected no beat", out_data);
          end else begin
            e = q.pop_front();
            check("out_data", out_data, e.data);
            check("out_sat", out_sat, e.sat);
            check("out_last", out_last, e.last);
            if (e.chk_lat) check("latency", cyc + 1 - e.acc_cyc, LATENCY);
            exp_cnt = sat_add16(exp_cnt, 16'($countones(e.sat)));
          end
        end
        prev_stall = out_valid && !out_ready;
        sv_data = out_data; sv_sat = out_sat; sv_last = out_last;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, expected completion before time limit");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   a[4];
    exp_t e;
    rq_param_t p_col_old, p_col_new;

    vt[0] = '{mk(-4, 16384, 14, -3, -128, 127), 0, '{100, 0, -100, 5},
              '{45, -5, -55, -2}, 4'b0000};
    vt[1] = '{mk(0, 1, 0, 0, -128, 127), 1, '{3, -3, 1, -1},
              '{2, -1, 1, 0}, 4'b0000};
    vt[2] = '{mk(0, 16384, 14, 0, 0, 127), 2, '{1000, -100, 20, 0},
              '{127, 0, 10, 0}, 4'b0011};
    vt[3] = '{mk(0, 16384, 14, 0, 10, -10), 5, '{0, 100, -100, 30},
              '{-10, -10, -10, -10}, 4'b1111};
    vt[4] = '{mk(127, 32767, 0, 0, -128, 127), 6, '{8388607, -8388608, 0, -127},
              '{127, -128, 127, 0}, 4'b0111};
    p_col_old = mk(0, 16384, 14, 0, -128, 127);
    p_col_new = mk(0, 16384, 14, 10, -128, 127);

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    in_valid = 1'b0; in_ch = '0; in_acc = '0; in_last = 1'b0;

    // Reset state.
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_out_last", out_last, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table, back to back.
    for (int i = 0; i < 5; i++) cfg_write(vt[i].ch, vt[i].p);
    cfg_write(3, p_col_old);
    for (int i = 0; i < 5; i++) begin
      send_beat(vt[i].ch, pack_acc(vt[i].acc), 1'b0,
                exp_from(vt[i].y, vt[i].sat, 1'b0, 1'b1));
    end
    drain(50);

    // Config write colliding with a beat on the same channel.
    a = '{10, -10, 0, 40};
    cfg_we = 1'b1; cfg_addr = AW'(3); cfg_wdata = p_col_new;
    send_beat(3, pack_acc(a), 1'b0, exp_from('{5, -5, 0, 20}, 4'b0000, 1'b0, 1'b1));
    cfg_we = 1'b0;
    send_beat(3, pack_acc(a), 1'b0, exp_from('{15, 5, 10, 30}, 4'b0000, 1'b0, 1'b1));
    drain(50);

    // Backpressure: 8 beats, last on the eighth.
    bp_mode = 1;
    @(posedge clk); #1;
    for (int b = 0; b < 8; b++) begin
      for (int l = 0; l < 4; l++) a[l] = int'($urandom_range(4000)) - 2000;
      e = model_beat(vt[0].p, a, b == 7);
      send_beat(0, pack_acc(a), b == 7, e);
    end
    drain(200);
    bp_mode = 0;
    repeat (3) @(posedge clk); #1;

    // Reset with beats in flight.
    for (int b = 0; b < 6; b++) begin
      a = '{100 + b * 10, 200, -300, 50};
      send_beat(0, pack_acc(a), 1'b0, model_beat(vt[0].p, a, 1'b0));
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_sat", out_sat, 0);
    check("midrst_out_last", out_last, 0);
    check("midrst_sat_cnt", sat_cnt, 0);
    q.delete();
    exp_cnt = 16'd0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_sat_cnt", sat_cnt, 0);

    // Clamp counter saturation: every beat clamps all four lanes.
    e = exp_from(vt[3].y, vt[3].sat, 1'b0, 1'b1);
    for (int b = 0; b < 16400; b++) send_beat(vt[3].ch, pack_acc(vt[3].acc), 1'b0, e);
    drain(50);
    check("sat_cnt_ceiling", sat_cnt, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
